sram_arbiter: RTL

Shares the single DPI-backed SRAM slave between N bus masters: IFU fetch (index 0) and LSU load/store (index 1) by default. Runs one transaction at a time on the slave's AXI-lite-style AR/R/AW/W/B channels. Picks the winner by round-robin, locks the grant until the transaction's final response handshake, then re-arbitrates. Sits between the core's master ports and the SRAM module.

---
 rtl/sram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM slave between N bus masters.
// One transaction at a time; the grant is held until the final response.
module sram_arbiter #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    m_arvalid,
  input  logic [N-1:0]    m_awvalid,
  input  logic [N-1:0]    m_wvalid,
  input  logic [N-1:0]    m_rready,
  input  logic [N-1:0]    m_bready,
  input  logic [N*AW-1:0] m_araddr,
  input  logic [N*AW-1:0] m_awaddr,
  input  logic [N*DW-1:0] m_wdata,
  input  logic [N*DW-1:0] m_len,
  input  logic [N-1:0]    m_load_unsign,
  output logic [N-1:0]    m_arready,
  output logic [N-1:0]    m_awready,
  output logic [N-1:0]    m_wready,
  output logic [N-1:0]    m_rvalid,
  output logic [N-1:0]    m_rresp,
  output logic [N-1:0]    m_bvalid,
  output logic [N-1:0]    m_bresp,
  output logic [DW-1:0]   m_rdata,
  output logic            s_arvalid,
  output logic            s_awvalid,
  output logic            s_wvalid,
  output logic            s_rready,
  output logic            s_bready,
  output logic            s_load_unsign,
  output logic [AW-1:0]   s_araddr,
  output logic [AW-1:0]   s_awaddr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW-1:0]   s_len,
  input  logic            s_arready,
  input  logic            s_awready,
  input  logic            s_wready,
  input  logic            s_rvalid,
  input  logic            s_rresp,
  input  logic            s_bvalid,
  input  logic            s_bresp,
  input  logic [DW-1:0]   s_rdata,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t        state, state_n;
  logic [GW-1:0] gidx, gidx_n;
  logic [GW-1:0] last, last_n;
  logic [GW-1:0] cand;
  logic          found;
  logic [N-1:0]  req;

  logic [AW-1:0] araddr_a [N];
  logic [AW-1:0] awaddr_a [N];
  logic [DW-1:0] wdata_a  [N];
  logic [DW-1:0] len_a    [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign araddr_a[i] = m_araddr[i*AW +: AW];
    assign awaddr_a[i] = m_awaddr[i*AW +: AW];
    assign wdata_a[i]  = m_wdata[i*DW +: DW];
    assign len_a[i]    = m_len[i*DW +: DW];
  end

  assign req     = m_arvalid | m_awvalid;
  assign m_rdata = s_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gidx  <= '0;
      last  <= GW'(N - 1);
    end else begin
      state <= state_n;
      gidx  <= gidx_n;
      last  <= last_n;
    end
  end

  // Rotating search starts just past the previous owner.
  always_comb begin
    state_n = state;
    gidx_n  = gidx;
    last_n  = last;
    cand    = '0;
    found   = 1'b0;
    unique case (state)
      IDLE: begin
        for (int k = 1; k <= N; k++) begin
          cand = GW'((int'(last) + k) % N);
          if (!found && req[cand]) begin
            found  = 1'b1;
            gidx_n = cand;
          end
        end
        if (found)
          state_n = m_arvalid[gidx_n] ? READ : WRITE;
      end
      READ: begin
        if (s_rvalid && m_rready[gidx]) begin
          state_n = IDLE;
          last_n  = gidx;
        end
      end
      WRITE: begin
        if (s_bvalid && m_bready[gidx]) begin
          state_n = IDLE;
          last_n  = gidx;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    m_arready     = '0;
    m_awready     = '0;
    m_wready      = '0;
    m_rvalid      = '0;
    m_rresp       = '0;
    m_bvalid      = '0;
    m_bresp       = '0;
    s_arvalid     = 1'b0;
    s_awvalid     = 1'b0;
    s_wvalid      = 1'b0;
    s_rready      = 1'b0;
    s_bready      = 1'b0;
    s_load_unsign = 1'b0;
    s_araddr      = '0;
    s_awaddr      = '0;
    s_wdata       = '0;
    s_len         = '0;
    grant         = '0;
    busy          = 1'b0;
    // The SRAM's bresp trails the B handshake, so route it outside WRITE.
    m_bresp[gidx] = s_bresp && !reset;
    unique case (state)
      READ: begin
        grant[gidx]     = 1'b1;
        busy            = 1'b1;
        s_arvalid       = m_arvalid[gidx];
        s_araddr        = araddr_a[gidx];
        s_len           = len_a[gidx];
        s_load_unsign   = m_load_unsign[gidx];
        s_rready        = m_rready[gidx];
        m_arready[gidx] = s_arready;
        m_rvalid[gidx]  = s_rvalid;
        m_rresp[gidx]   = s_rresp;
      end
      WRITE: begin
        grant[gidx]     = 1'b1;
        busy            = 1'b1;
        s_awvalid       = m_awvalid[gidx];
        s_awaddr        = awaddr_a[gidx];
        s_wvalid        = m_wvalid[gidx];
        s_wdata         = wdata_a[gidx];
        s_len           = len_a[gidx];
        s_bready        = m_bready[gidx];
        m_awready[gidx] = s_awready;
        m_wready[gidx]  = s_wready;
        m_bvalid[gidx]  = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule
